realtank_soc_bus_in_stage: RTL and testbench
============================================

Name: realtank_soc_bus_in_stage

Overview:
- Per-master input stage of the RealTank SoC AHB bus matrix. It is the requester end of the output-stage arbitration handshake.
- Presents each master address phase to the decoder and output stages and raises a request toward the arbiters.
- When the target output port is not granted, it captures the address phase into a holding register and stalls the master (HREADYOUTS=0) until the grant arrives.
- It also tracks the data phase so that slave HREADYOUT/HRESP from the granted output stage is returned to the master.

Parameters:
- ADDR_WIDTH, 32, width of HADDR through the stage.

Ports:
- HCLK  in  1  AHB system clock.
- HRESETn  in  1  reset, synchronous, active-low; sampled on rising HCLK.
- HSELS  in  1  master-side select.
- HADDRS  in  ADDR_WIDTH  master address.
- HTRANSS  in  2  master transfer type.
- HWRITES  in  1  master write.
- HSIZES  in  3  master size.
- HBURSTS  in  3  master burst type.
- HPROTS  in  4  master protection.
- HMASTLOCKS  in  1  master lock.
- HREADYS  in  1  bus-level HREADY seen by master.
- active_dec  in  1  output stage has granted this port the address phase this cycle.
- readyout_dec  in  1  HREADYOUT from the output stage owning this port's data phase.
- resp_dec  in  1  HRESP from the same output stage.
- HSELM  out  1  select toward decoder: pend_reg | HSELS.
- HADDRM  out  ADDR_WIDTH  held or live address.
- HTRANSM  out  2  held or live transfer type.
- HWRITEM  out  1  held or live write.
- HSIZEM  out  3  held or live size.
- HBURSTM  out  3  held or live burst.
- HPROTM  out  4  held or live prot.
- HMASTLOCKM  out  1  held or live lock.
- req_port  out  1  request to output-stage arbiters: pend_reg | trans_valid.
- HREADYOUTS  out  1  ready returned to master.
- HRESPS  out  1  response returned to master (0=OKAY, 1=ERROR).

Behaviour:
- trans_valid = HSELS & HTRANSS[1] & HREADYS, i.e. a NONSEQ or SEQ address phase is completing on the master side.
- Holding registers reg_addr/trans/write/size/burst/prot/lock are loaded when trans_valid is 1, irrespective of grant.
- pend_reg next state:
  - set when trans_valid & ~active_dec;
  - cleared when pend_reg & active_dec;
  - otherwise held.
  - Simultaneous set and clear cannot occur: trans_valid requires HREADYS=1, which is impossible while pend_reg=1 because HREADYOUTS=0.
- Output mux: when pend_reg=1, all *M address outputs come from the holding registers; otherwise they pass HxxxS straight through.
- Interrupted burst: if the held HTRANS is SEQ, HTRANSM is driven NONSEQ and HBURSTM is driven INCR (3'b001). This lets a fresh arbitration start a burst the output stage can track.
- data_phase_reg:
  - set on (trans_valid & active_dec) | (pend_reg & active_dec);
  - cleared when data_phase_reg & readyout_dec and no new accepted transfer occurs that cycle;
  - back-to-back transfers keep it at 1.
- HREADYOUTS = pend_reg ? 0 : (data_phase_reg ? readyout_dec : 1).
- HRESPS = data_phase_reg ? resp_dec : 0. Two-cycle ERROR passes through unchanged.
- IDLE/BUSY transfers (HTRANSS[1]=0) never set pend_reg and never raise req_port. HSELM still follows HSELS so the output stage sees IDLE to the selected slave.
- Reset: registers clear on the first rising HCLK edge with HRESETn=0.
  - pend_reg=0, data_phase_reg=0, all holding registers 0.
  - Resulting outputs: HREADYOUTS=1, HRESPS=0, req_port=trans_valid, HTRANSM=HTRANSS passthrough.
  - Reset while pending discards the held transfer; no request survives reset.
- Latency: a granted transfer passes through with zero cycles added. A denied transfer adds exactly N wait states, where N = cycles until active_dec is asserted.

Test Plan:
- Reset with HSELS=1, HTRANSS=NONSEQ, HRESETn=0 held over 2 edges -> HREADYOUTS=1, HRESPS=0, pend_reg=0 after first edge.
- NONSEQ to 0x2000_0010 with active_dec=1, readyout_dec=1 -> HADDRM=0x2000_0010 same cycle, req_port=1, no wait states, data_phase_reg=1 next cycle.
- NONSEQ write to 0x4000_0000 with active_dec=0 for 3 cycles, then 1 -> HREADYOUTS=0 for 3 cycles, HADDRM=0x4000_0000, HWRITEM=1 held throughout, pend clears on grant, data phase follows.
- INCR4 burst de-granted at beat 3 (SEQ to 0x...08, active_dec=0) -> held output HTRANSM=2'b10, HBURSTM=3'b001 until regranted.
- Slave ERROR: readyout_dec=0, resp_dec=1, then readyout_dec=1, resp_dec=1 -> HREADYOUTS 0 then 1, HRESPS 1 both cycles, data_phase_reg=0 after.
- Assert HRESETn=0 while pend_reg=1 -> next edge pend_reg=0, HREADYOUTS=1, req_port=0 if HTRANSS=IDLE.

Source files
------------

// File: rtl/realtank_soc_bus_in_stage_if.sv
// rtl/realtank_soc_bus_in_stage_if.sv - bus bundle between a master port and its matrix input stage
interface realtank_soc_bus_in_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  active_dec;
  logic                  readyout_dec;
  logic                  resp_dec;
  logic                  HSELM;
  logic [ADDR_WIDTH-1:0] HADDRM;
  logic [1:0]            HTRANSM;
  logic                  HWRITEM;
  logic [2:0]            HSIZEM;
  logic [2:0]            HBURSTM;
  logic [3:0]            HPROTM;
  logic                  HMASTLOCKM;
  logic                  req_port;
  logic                  HREADYOUTS;
  logic                  HRESPS;

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    output active_dec, readyout_dec, resp_dec,
    input  HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM,
    input  req_port, HREADYOUTS, HRESPS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    input  active_dec, readyout_dec, resp_dec,
    output HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM,
    output req_port, HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/realtank_soc_bus_in_stage.sv
// rtl/realtank_soc_bus_in_stage.sv - AHB matrix input stage: holds denied address phases and tracks the data phase
module realtank_soc_bus_in_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  realtank_soc_bus_in_stage_if.slave      bus
);
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_trans;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [2:0]            r_burst;
  logic [3:0]            r_prot;
  logic                  r_lock;
  logic                  r_pend;
  logic                  r_data_phase;

  logic w_trans_valid;
  logic w_grant_now;

  assign w_trans_valid = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  assign w_grant_now   = (w_trans_valid | r_pend) & bus.active_dec;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_addr       <= '0;
      r_trans      <= '0;
      r_write      <= 1'b0;
      r_size       <= '0;
      r_burst      <= '0;
      r_prot       <= '0;
      r_lock       <= 1'b0;
      r_pend       <= 1'b0;
      r_data_phase <= 1'b0;
    end else begin
      if (w_trans_valid) begin
        r_addr  <= bus.HADDRS;
        r_trans <= bus.HTRANSS;
        r_write <= bus.HWRITES;
        r_size  <= bus.HSIZES;
        r_burst <= bus.HBURSTS;
        r_prot  <= bus.HPROTS;
        r_lock  <= bus.HMASTLOCKS;
      end
      // A pending transfer forces HREADYS low, so set and clear never coincide.
      if (w_trans_valid && !bus.active_dec) begin
        r_pend <= 1'b1;
      end else if (r_pend && bus.active_dec) begin
        r_pend <= 1'b0;
      end
      if (w_grant_now) begin
        r_data_phase <= 1'b1;
      end else if (r_data_phase && bus.readyout_dec) begin
        r_data_phase <= 1'b0;
      end
    end
  end

  // A re-arbitrated SEQ beat restarts as an undefined-length burst.
  always_comb begin
    bus.HSELM      = r_pend | bus.HSELS;
    bus.HADDRM     = bus.HADDRS;
    bus.HTRANSM    = bus.HTRANSS;
    bus.HWRITEM    = bus.HWRITES;
    bus.HSIZEM     = bus.HSIZES;
    bus.HBURSTM    = bus.HBURSTS;
    bus.HPROTM     = bus.HPROTS;
    bus.HMASTLOCKM = bus.HMASTLOCKS;
    if (r_pend) begin
      bus.HADDRM     = r_addr;
      bus.HTRANSM    = (r_trans == TRANS_SEQ) ? TRANS_NONSEQ : r_trans;
      bus.HWRITEM    = r_write;
      bus.HSIZEM     = r_size;
      bus.HBURSTM    = (r_trans == TRANS_SEQ) ? BURST_INCR : r_burst;
      bus.HPROTM     = r_prot;
      bus.HMASTLOCKM = r_lock;
    end
  end

  assign bus.req_port   = r_pend | w_trans_valid;
  assign bus.HREADYOUTS = r_pend ? 1'b0 : (r_data_phase ? bus.readyout_dec : 1'b1);
  assign bus.HRESPS     = r_data_phase ? bus.resp_dec : 1'b0;
endmodule

// File: tb/tb_realtank_soc_bus_in_stage.sv
// tb/tb_realtank_soc_bus_in_stage.sv - randomized bench for the AHB matrix input stage against a transaction model
module tb_realtank_soc_bus_in_stage;
  logic HCLK = 1'b0;
  logic HRESETn;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 HCLK = ~HCLK;

  realtank_soc_bus_in_stage_if #(.ADDR_WIDTH(32)) bus ();

  // Single master on the bus: the master sees its own stage's ready.
  assign bus.HREADYS = bus.HREADYOUTS;

  realtank_soc_bus_in_stage #(.ADDR_WIDTH(32)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic        w;
    logic [2:0]  s;
    logic [2:0]  b;
    logic [3:0]  p;
    logic        l;
  } ap_t;

  ap_t  held_q[$];
  logic in_data_phase;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rstn, input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] ad, input logic [2:0] bu,
                      input logic act, input logic rdy, input logic rsp);
    ap_t  live;
    ap_t  shown;
    logic waiting;
    logic exp_ready;
    logic accepted;
    @(posedge HCLK);
    #1;
    HRESETn          = rstn;
    bus.HSELS        = sel;
    bus.HTRANSS      = tr;
    bus.HWRITES      = wr;
    bus.HADDRS       = ad;
    bus.HBURSTS      = bu;
    bus.HSIZES       = 3'($urandom_range(0, 2));
    bus.HPROTS       = 4'($urandom);
    bus.HMASTLOCKS   = 1'($urandom);
    bus.active_dec   = act;
    bus.readyout_dec = rdy;
    bus.resp_dec     = rsp;
    #4;
    live = '{a: ad, t: tr, w: wr, s: bus.HSIZES, b: bu, p: bus.HPROTS, l: bus.HMASTLOCKS};
    waiting = (held_q.size() != 0);
    if (waiting) begin
      shown = held_q[0];
      if (shown.t == 2'b11) begin
        shown.t = 2'b10;
        shown.b = 3'b001;
      end
    end else begin
      shown = live;
    end
    if (waiting)            exp_ready = 1'b0;
    else if (in_data_phase) exp_ready = rdy;
    else                    exp_ready = 1'b1;
    accepted = sel && tr[1] && exp_ready;

    chk("hreadyouts", bus.HREADYOUTS, exp_ready);
    chk("hresps",     bus.HRESPS,     in_data_phase ? rsp : 1'b0);
    chk("req_port",   bus.req_port,   waiting || accepted);
    chk("hselm",      bus.HSELM,      waiting || sel);
    chk("haddrm",     bus.HADDRM,     shown.a);
    chk("htransm",    bus.HTRANSM,    shown.t);
    chk("hwritem",    bus.HWRITEM,    shown.w);
    chk("hsizem",     bus.HSIZEM,     shown.s);
    chk("hburstm",    bus.HBURSTM,    shown.b);
    chk("hprotm",     bus.HPROTM,     shown.p);
    chk("hmastlockm", bus.HMASTLOCKM, shown.l);

    if (!rstn) begin
      held_q.delete();
      in_data_phase = 1'b0;
    end else begin
      if (in_data_phase && rdy) in_data_phase = 1'b0;
      if (waiting && act) begin
        void'(held_q.pop_front());
        in_data_phase = 1'b1;
      end
      if (accepted) begin
        if (act) in_data_phase = 1'b1;
        else     held_q.push_back(live);
      end
    end
  endtask

  initial begin
    held_q.delete();
    in_data_phase    = 1'b0;
    HRESETn          = 1'b0;
    bus.HSELS        = 1'b1;
    bus.HTRANSS      = 2'b10;
    bus.HWRITES      = 1'b0;
    bus.HADDRS       = '0;
    bus.HSIZES       = '0;
    bus.HBURSTS      = '0;
    bus.HPROTS       = '0;
    bus.HMASTLOCKS   = 1'b0;
    bus.active_dec   = 1'b0;
    bus.readyout_dec = 1'b1;
    bus.resp_dec     = 1'b0;
    @(posedge HCLK);

    // reset held with a live NONSEQ
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);

    // granted NONSEQ then idle data phase
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h2000_0010, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("grant_no_wait", bus.HREADYOUTS, 1'b1);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);

    // denied write: three stall cycles then grant
    step(1'b1, 1'b1, 2'b10, 1'b1, 32'h4000_0000, 3'b000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 2'b10, 1'b1, 32'h4000_0000, 3'b000, (i == 2), 1'b1, 1'b0);
      chk("stall_ready", bus.HREADYOUTS, 1'b0);
      chk("stall_addr",  bus.HADDRM, 32'h4000_0000);
    end
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);

    // INCR4 burst de-granted at beat 3
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h1000_0000, 3'b011, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'b11, 1'b0, 32'h1000_0004, 3'b011, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'b11, 1'b0, 32'h1000_0008, 3'b011, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'b11, 1'b0, 32'h1000_0008, 3'b011, 1'b0, 1'b1, 1'b0);
    chk("burst_htrans", bus.HTRANSM, 2'b10);
    chk("burst_hburst", bus.HBURSTM, 3'b001);
    step(1'b1, 1'b1, 2'b11, 1'b0, 32'h1000_0008, 3'b011, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);

    // two-cycle ERROR response
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h3000_0000, 3'b000, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("err_cycle1", {bus.HREADYOUTS, bus.HRESPS}, 2'b01);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1);
    chk("err_cycle2", {bus.HREADYOUTS, bus.HRESPS}, 2'b11);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1);

    // reset while pending discards the held transfer
    step(1'b1, 1'b1, 2'b10, 1'b1, 32'h5000_0000, 3'b000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("rst_pend_req", bus.req_port, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) >= 2), 1'($urandom_range(0, 9) < 8), 2'($urandom),
           1'($urandom), $urandom, 3'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
